// File: rtl/instruction_prefetch_axil_pkg.sv
// Shared types and constants for the instruction prefetch unit.
//   XLEN            : data / PC width
//   AXI_RESP_*      : AXI read response encodings
//   ar_state_e      : read-address channel states
//   fetch_entry_t   : one prefetch buffer entry {instruction, pc, error}
package instruction_prefetch_axil_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_WAIT = 1'b1
  } ar_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            err;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_prefetch_axil_if.sv
// AXI4-Lite read-only bus (AR + R channels).
//   master : drives araddr/arvalid/rready, samples arready/rdata/rresp/rvalid
//   slave  : the opposite direction
interface instruction_prefetch_axil_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/instruction_prefetch_axil_fifo.sv
// Synchronous prefetch buffer with flush; head entry is visible combinationally
// from storage so it stays stable until popped.
//   i_Clock, i_Reset_N : clock, async active-low reset
//   i_Flush            : empty the buffer (wins over push/pop)
//   i_Push, i_Data     : write one entry
//   i_Pop              : drop the head entry
//   o_Head             : current head entry
//   o_Count            : number of valid entries
module instruction_prefetch_axil_fifo
  import instruction_prefetch_axil_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset_N,
  input  logic                         i_Flush,
  input  logic                         i_Push,
  input  fetch_entry_t                 i_Data,
  input  logic                         i_Pop,
  output fetch_entry_t                 o_Head,
  output logic [$clog2(DEPTH+1)-1:0]   o_Count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage, pointers and occupancy; push into a full buffer is legal only with a pop.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_Push) begin
        r_mem[r_wr_ptr] <= i_Data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (i_Pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(i_Push) - CW'(i_Pop);
    end
  end

  assign o_Head  = r_mem[r_rd_ptr];
  assign o_Count = r_count;
endmodule

// File: rtl/instruction_prefetch_axil.sv
// Instruction prefetch unit: issues AXI4-Lite reads ahead of the core, keeps up
// to FIFO_DEPTH reads in flight, buffers the returned words with their PC and
// hands them over on a valid/ready handshake. Redirect flushes the buffer and
// discards responses of reads already issued.
//   i_Clock, i_Reset_N   : clock, async active-low reset
//   i_Redirect(_Addr)    : one-cycle restart of fetch at a new word-aligned PC
//   o_Instruction*       : head-of-buffer word, PC, error flag, valid
//   i_Instruction_Ready  : core accepts head
//   m_axil               : AXI4-Lite read master
module instruction_prefetch_axil
  import instruction_prefetch_axil_pkg::*;
#(
  parameter int unsigned    ADDR_WIDTH = 16,
  parameter int unsigned    FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_N,
  input  logic                       i_Redirect,
  input  logic [XLEN-1:0]            i_Redirect_Addr,
  output logic [XLEN-1:0]            o_Instruction,
  output logic [XLEN-1:0]            o_Instruction_Addr,
  output logic                       o_Instruction_Error,
  output logic                       o_Instruction_Valid,
  input  logic                       i_Instruction_Ready,
  instruction_prefetch_axil_if.master m_axil
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  ar_state_e             r_ar_state;
  logic                  r_arvalid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [XLEN-1:0]       r_fetch_pc;   // next address to put on AR
  logic [XLEN-1:0]       r_resp_pc;    // PC of the next kept R beat
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_drop;

  logic                  w_ar_hs;
  logic                  w_r_beat;
  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_count_next;
  logic [CW-1:0]         w_out_next;
  logic [CW-1:0]         w_drop_redirect;
  logic                  w_credit;
  logic [XLEN-1:0]       w_redirect_pc;
  logic [XLEN-1:0]       w_issue_pc;
  fetch_entry_t          w_head;
  fetch_entry_t          w_push_data;
  logic                  w_unused;

  assign w_redirect_pc = {i_Redirect_Addr[XLEN-1:2], 2'b00};
  assign w_unused      = &{1'b0, i_Redirect_Addr[1:0]};

  assign w_ar_hs  = r_arvalid & m_axil.arready;
  assign w_r_beat = m_axil.rvalid;
  assign w_push   = w_r_beat & (r_drop == '0) & ~i_Redirect;
  assign w_pop    = o_Instruction_Valid & i_Instruction_Ready & ~i_Redirect;

  assign w_out_next   = r_outstanding + CW'(w_ar_hs) - CW'(w_r_beat);
  assign w_count_next = i_Redirect ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
  // Buffer space is reserved for every read in flight, so R never needs backpressure.
  assign w_credit     = (({1'b0, w_count_next} + {1'b0, w_out_next}) < (CW+1)'(FIFO_DEPTH));
  // A still-pending AR becomes outstanding later; its response must be discarded too.
  assign w_drop_redirect = w_out_next + CW'(r_arvalid & ~m_axil.arready);
  assign w_issue_pc      = i_Redirect ? w_redirect_pc : r_fetch_pc;

  assign w_push_data = '{instr: m_axil.rdata, pc: r_resp_pc,
                         err: (m_axil.rresp != AXI_RESP_OKAY)};

  // AR channel FSM plus outstanding/drop bookkeeping.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      r_ar_state    <= AR_IDLE;
      r_arvalid     <= 1'b0;
      r_araddr      <= '0;
      r_fetch_pc    <= RESET_ADDR;
      r_resp_pc     <= RESET_ADDR;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_out_next;

      if (i_Redirect) begin
        r_drop     <= w_drop_redirect;
        r_resp_pc  <= w_redirect_pc;
        r_fetch_pc <= w_redirect_pc;
      end else if (w_r_beat) begin
        if (r_drop != '0) r_drop    <= r_drop - CW'(1);
        else              r_resp_pc <= r_resp_pc + XLEN'(4);
      end

      case (r_ar_state)
        AR_IDLE: begin
          if (w_credit) begin
            r_ar_state <= AR_WAIT;
            r_arvalid  <= 1'b1;
            r_araddr   <= ADDR_WIDTH'(w_issue_pc);
            r_fetch_pc <= w_issue_pc + XLEN'(4);
          end
        end
        AR_WAIT: begin
          // Address held until accepted; back-to-back issue keeps 1 read per cycle.
          if (w_ar_hs) begin
            if (w_credit && !i_Redirect) begin
              r_araddr   <= ADDR_WIDTH'(r_fetch_pc);
              r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end else begin
              r_ar_state <= AR_IDLE;
              r_arvalid  <= 1'b0;
            end
          end
        end
        default: r_ar_state <= AR_IDLE;
      endcase
    end
  end

  instruction_prefetch_axil_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_N (i_Reset_N),
    .i_Flush   (i_Redirect),
    .i_Push    (w_push),
    .i_Data    (w_push_data),
    .i_Pop     (w_pop),
    .o_Head    (w_head),
    .o_Count   (w_count)
  );

  assign m_axil.arvalid = r_arvalid;
  assign m_axil.araddr  = r_araddr;
  assign m_axil.rready  = 1'b1;

  assign o_Instruction       = w_head.instr;
  assign o_Instruction_Addr  = w_head.pc;
  assign o_Instruction_Error = w_head.err;
  assign o_Instruction_Valid = (w_count != '0);
endmodule

// File: tb/tb_instruction_prefetch_axil.sv
// Directed bench for instruction_prefetch_axil with a small AXI4-Lite RAM model
// (arready delay, AR/R beat budgets, single-address error injection).
module tb_instruction_prefetch_axil;
  import instruction_prefetch_axil_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            redirect = 1'b0;
  logic [31:0]     redirect_addr = '0;
  logic [31:0]     instr, instr_addr;
  logic            instr_err, instr_valid;
  logic            instr_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  // Slave model knobs
  int          ar_delay = 0;
  int          ar_allow = 1000;
  int          r_allow  = 1000;
  logic        err_en   = 1'b0;
  logic [15:0] err_addr = '0;

  // Slave model state
  int          ar_cnt;
  int          ar_hs_count;
  int          r_sent;
  logic [15:0] rq[$];
  logic [15:0] ar_log[$];

  instruction_prefetch_axil_if #(.ADDR_WIDTH(16)) axil ();

  instruction_prefetch_axil #(
    .ADDR_WIDTH (16),
    .FIFO_DEPTH (4),
    .RESET_ADDR (32'h0)
  ) dut (
    .i_Clock             (clk),
    .i_Reset_N           (rst_n),
    .i_Redirect          (redirect),
    .i_Redirect_Addr     (redirect_addr),
    .o_Instruction       (instr),
    .o_Instruction_Addr  (instr_addr),
    .o_Instruction_Error (instr_err),
    .o_Instruction_Valid (instr_valid),
    .i_Instruction_Ready (instr_ready),
    .m_axil              (axil)
  );

  always #5 clk = ~clk;

  assign axil.arready = (ar_cnt >= ar_delay) && (ar_hs_count < ar_allow);

  // RAM model: one R beat per cycle from the accepted-address queue.
  always @(posedge clk or negedge rst_n) begin
    int sent;
    if (!rst_n) begin
      rq.delete();
      ar_log.delete();
      ar_cnt      <= 0;
      ar_hs_count <= 0;
      r_sent      <= 0;
      axil.rvalid <= 1'b0;
      axil.rdata  <= '0;
      axil.rresp  <= '0;
    end else begin
      sent = r_sent;
      if (axil.rvalid && axil.rready) begin
        void'(rq.pop_front());
        sent++;
      end
      if (axil.arvalid && axil.arready) begin
        rq.push_back(axil.araddr);
        ar_log.push_back(axil.araddr);
        ar_hs_count <= ar_hs_count + 1;
        ar_cnt      <= 0;
      end else if (axil.arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end else begin
        ar_cnt <= 0;
      end
      r_sent <= sent;
      if (rq.size() > 0 && sent < r_allow) begin
        axil.rvalid <= 1'b1;
        axil.rdata  <= 32'hC0DE_0000 | 32'(rq[0]);
        axil.rresp  <= (err_en && rq[0] == err_addr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else begin
        axil.rvalid <= 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    ar_delay      = 0;
    ar_allow      = 1000;
    r_allow       = 1000;
    err_en        = 1'b0;
    err_addr      = '0;
    redirect      = 1'b0;
    redirect_addr = '0;
  endtask

  // Holds reset over two edges; returns just after the releasing negedge.
  task automatic apply_reset();
    rst_n = 1'b0;
    set_defaults();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, output logic ok);
    int n = 0;
    while (!instr_valid && n < max_cycles) begin
      step();
      n++;
    end
    ok = instr_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_defaults();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (axil.arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b exp=0", axil.arvalid); end
    checks++; if (axil.araddr !== 16'h0) begin failures++; $display("FAIL reset_araddr got=%h exp=0", axil.araddr); end
    checks++; if (axil.rready !== 1'b1) begin failures++; $display("FAIL reset_rready got=%b exp=1", axil.rready); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr); end
    checks++; if (instr_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", instr_addr); end
    checks++; if (instr_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", instr_err); end
  endtask

  task automatic test_stream();
    instr_ready = 1'b1;
    apply_reset();
    step();  // edge 0
    checks++; if (axil.arvalid !== 1'b1 || axil.araddr !== 16'h0) begin failures++; $display("FAIL stream_first_ar got=%b/%h exp=1/0000", axil.arvalid, axil.araddr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_c1 got=%b exp=0", instr_valid); end
    step();  // edge 1
    checks++; if (axil.araddr !== 16'h4) begin failures++; $display("FAIL stream_second_ar got=%h exp=0004", axil.araddr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_c2 got=%b exp=0", instr_valid); end
    step();  // edge 2: first word visible in cycle 3
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== 32'(4*i) || instr !== (32'hC0DE_0000 | 32'(4*i)) || instr_err !== 1'b0) begin
        failures++;
        $display("FAIL stream_word%0d got v=%b a=%h d=%h e=%b exp v=1 a=%h d=%h e=0", i, instr_valid, instr_addr, instr, instr_err, 32'(4*i), 32'hC0DE_0000 | 32'(4*i));
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    apply_reset();
    repeat (20) step();
    checks++; if (ar_hs_count !== 4) begin failures++; $display("FAIL bp_ar_count got=%0d exp=4", ar_hs_count); end
    checks++; if (axil.arvalid !== 1'b0) begin failures++; $display("FAIL bp_arvalid got=%b exp=0", axil.arvalid); end
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 32'h0 || instr !== 32'hC0DE_0000) begin failures++; $display("FAIL bp_head got v=%b a=%h d=%h exp v=1 a=0 d=c0de0000", instr_valid, instr_addr, instr); end
    @(negedge clk);
    instr_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== 32'(4*i)) begin
        failures++;
        $display("FAIL bp_drain%0d got v=%b a=%h exp v=1 a=%h", i, instr_valid, instr_addr, 32'(4*i));
      end
      step();
    end
  endtask

  task automatic test_redirect_outstanding();
    logic ok;
    instr_ready = 1'b0;
    apply_reset();
    r_allow = 2;
    repeat (15) step();
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 32'h0 || axil.arvalid !== 1'b0) begin failures++; $display("FAIL redir_setup got v=%b a=%h arv=%b exp v=1 a=0 arv=0", instr_valid, instr_addr, axil.arvalid); end
    @(negedge clk);
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0102;  // low bits ignored
    r_allow       = 1000;
    step();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b exp=0", instr_valid); end
    checks++; if (axil.arvalid !== 1'b1 || axil.araddr !== 16'h0100) begin failures++; $display("FAIL redir_new_ar got=%b/%h exp=1/0100", axil.arvalid, axil.araddr); end
    @(negedge clk);
    instr_ready = 1'b1;
    wait_valid(20, ok);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== (32'h100 + 32'(4*i)) || instr !== (32'hC0DE_0100 + 32'(4*i))) begin
        failures++;
        $display("FAIL redir_word%0d got v=%b a=%h d=%h exp v=1 a=%h", i, instr_valid, instr_addr, instr, 32'h100 + 32'(4*i));
      end
      step();
    end
  endtask

  task automatic test_redirect_pending();
    logic ok;
    instr_ready = 1'b1;
    apply_reset();
    ar_delay = 3;
    step();  // edge 0: AR for 0x0 raised
    step();  // edge 1
    @(negedge clk);
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0100;
    step();  // edge 2
    redirect = 1'b0;
    checks++; if (axil.arvalid !== 1'b1 || axil.araddr !== 16'h0) begin failures++; $display("FAIL pend_hold1 got=%b/%h exp=1/0000", axil.arvalid, axil.araddr); end
    step();  // edge 3
    checks++; if (axil.arvalid !== 1'b1 || axil.araddr !== 16'h0) begin failures++; $display("FAIL pend_hold2 got=%b/%h exp=1/0000", axil.arvalid, axil.araddr); end
    wait_valid(40, ok);
    checks++; if (ok !== 1'b1 || instr_addr !== 32'h100) begin failures++; $display("FAIL pend_first_word got v=%b a=%h exp v=1 a=100", ok, instr_addr); end
    checks++;
    if (ar_log.size() < 2) begin
      failures++; $display("FAIL pend_ar_log got size=%0d exp>=2", ar_log.size());
    end else if (ar_log[0] !== 16'h0 || ar_log[1] !== 16'h100) begin
      failures++; $display("FAIL pend_ar_log got %h,%h exp 0000,0100", ar_log[0], ar_log[1]);
    end
  endtask

  task automatic test_slave_error();
    logic ok;
    logic [31:0] a;
    logic        e;
    instr_ready = 1'b1;
    apply_reset();
    err_en   = 1'b1;
    err_addr = 16'h0008;
    wait_valid(20, ok);
    for (int i = 0; i < 4; i++) begin
      a = 32'(4*i);
      e = (i == 2);
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== a || instr_err !== e || instr !== (32'hC0DE_0000 | a)) begin
        failures++;
        $display("FAIL err_word%0d got v=%b a=%h e=%b d=%h exp v=1 a=%h e=%b", i, instr_valid, instr_addr, instr_err, instr, a, e);
      end
      step();
    end
  endtask

  task automatic test_reset_midstream();
    logic ok;
    instr_ready = 1'b0;
    apply_reset();
    ar_allow = 4;
    r_allow  = 1;
    repeat (12) step();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'hC0DE_0000 || ar_hs_count !== 4) begin failures++; $display("FAIL mid_setup got v=%b d=%h ars=%0d exp v=1 d=c0de0000 ars=4", instr_valid, instr, ar_hs_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_addr !== 32'h0 || axil.arvalid !== 1'b0 || axil.araddr !== 16'h0) begin
      failures++;
      $display("FAIL mid_async_reset got v=%b d=%h a=%h arv=%b ara=%h exp all 0", instr_valid, instr, instr_addr, axil.arvalid, axil.araddr);
    end
    set_defaults();
    instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(20, ok);
    checks++; if (ok !== 1'b1 || instr_addr !== 32'h0 || instr !== 32'hC0DE_0000) begin failures++; $display("FAIL mid_restart got v=%b a=%h d=%h exp v=1 a=0 d=c0de0000", ok, instr_addr, instr); end
    checks++; if (ar_log.size() < 1 || ar_log[0] !== 16'h0) begin failures++; $display("FAIL mid_restart_ar got size=%0d exp first addr 0000", ar_log.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_pending();
    test_slave_error();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
